// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-cold row drive, per-frame debounce, and
// direction/key-press decoding for the character movement logic.
module keypad_scan #(
  parameter logic [19:0] SCAN_DIV   = 20'd100000,
  parameter logic [3:0]  DEBOUNCE_N = 4'd4
) (
  input  logic       sys_clk,
  input  logic       RST_N,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] mov,
  output logic       key_valid,
  output logic [3:0] key_code
);

  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_state_t;

  row_state_t  r_state;
  logic [19:0] r_dwell;
  logic [3:0]  r_row_out;
  logic [15:0] r_frame;
  logic        r_frame_done;
  logic [15:0] r_prev_frame;
  logic [3:0]  r_stable_cnt;
  logic [15:0] r_debounced;
  logic [15:0] r_deb_seen;
  logic [3:0]  r_mov;
  logic        r_key_valid;
  logic [3:0]  r_key_code;

  logic        w_last;
  logic        w_equal;
  logic        w_onehot;
  logic        w_new_key;
  logic [3:0]  w_index;
  logic [3:0]  w_mov;
  logic        w_up;
  logic        w_down;
  logic        w_left;
  logic        w_right;

  assign w_last  = (r_dwell == SCAN_DIV - 20'd1);
  assign w_equal = (r_frame == r_prev_frame);

  // Columns are sampled only on the final dwell cycle so the row drive has settled.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ROW0;
      r_dwell      <= 20'd0;
      r_row_out    <= 4'b1110;
      r_frame      <= 16'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_last) begin
        r_dwell <= 20'd0;
        unique case (r_state)
          ROW0: begin
            r_frame[3:0] <= ~col_in;
            r_state      <= ROW1;
            r_row_out    <= 4'b1101;
          end
          ROW1: begin
            r_frame[7:4] <= ~col_in;
            r_state      <= ROW2;
            r_row_out    <= 4'b1011;
          end
          ROW2: begin
            r_frame[11:8] <= ~col_in;
            r_state       <= ROW3;
            r_row_out     <= 4'b0111;
          end
          ROW3: begin
            r_frame[15:12] <= ~col_in;
            r_state        <= ROW0;
            r_row_out      <= 4'b1110;
            r_frame_done   <= 1'b1;
          end
        endcase
      end else begin
        r_dwell <= r_dwell + 20'd1;
      end
    end
  end

  // The debounced map loads once, on the comparison that makes the run long enough.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      r_prev_frame <= 16'd0;
      r_stable_cnt <= 4'd0;
      r_debounced  <= 16'd0;
    end else if (r_frame_done) begin
      r_prev_frame <= r_frame;
      if (w_equal) begin
        if (r_stable_cnt < DEBOUNCE_N) begin
          r_stable_cnt <= r_stable_cnt + 4'd1;
        end
        if (r_stable_cnt == DEBOUNCE_N - 4'd1) begin
          r_debounced <= r_frame;
        end
      end else begin
        r_stable_cnt <= 4'd0;
      end
    end
  end

  assign w_up    = r_debounced[1];
  assign w_down  = r_debounced[9];
  assign w_left  = r_debounced[4];
  assign w_right = r_debounced[6];
  assign w_mov   = {w_up & ~w_down, w_down & ~w_up, w_left & ~w_right, w_right & ~w_left};

  assign w_onehot  = (r_debounced != 16'd0) &&
                     ((r_debounced & (r_debounced - 16'd1)) == 16'd0);
  assign w_new_key = (r_deb_seen == 16'd0) && w_onehot;

  always_comb begin
    w_index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_debounced[i]) begin
        w_index = 4'(i);
      end
    end
  end

  // r_deb_seen lags the debounced map by one cycle so a fresh press is seen exactly once.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      r_deb_seen  <= 16'd0;
      r_mov       <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
    end else begin
      r_deb_seen  <= r_debounced;
      r_mov       <= w_mov;
      r_key_valid <= w_new_key;
      if (w_new_key) begin
        r_key_code <= w_index;
      end
    end
  end

  assign row_out   = r_row_out;
  assign mov       = r_mov;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad model drives the columns and a
// frame-level reference model predicts mov, key_valid and key_code.
module tb_keypad_scan;

  localparam int SDI = 4;
  localparam int DNI = 3;

  logic        sys_clk = 1'b0;
  logic        RST_N   = 1'b1;
  logic [15:0] keys    = 16'd0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  mov;
  logic        key_valid;
  logic [3:0]  key_code;

  int total = 0;
  int bad   = 0;
  int pulses;

  keypad_scan #(.SCAN_DIV(20'd4), .DEBOUNCE_N(4'd3)) dut (
    .sys_clk  (sys_clk),
    .RST_N    (RST_N),
    .col_in   (col_in),
    .row_out  (row_out),
    .mov      (mov),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  always #5 sys_clk = ~sys_clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven low.
  function automatic logic [3:0] padCols(input logic [15:0] k, input logic [3:0] rows);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!rows[r]) c = c & ~k[r*4 +: 4];
    end
    return c;
  endfunction

  assign col_in = padCols(keys, row_out);

  function automatic logic [3:0] movOf(input logic [15:0] d);
    logic up, down, left, right;
    up = d[1]; down = d[9]; left = d[4]; right = d[6];
    return {up && !down, down && !up, left && !right, right && !left};
  endfunction

  function automatic logic [3:0] idxOf(input logic [15:0] d);
    logic [3:0] x;
    x = 4'd0;
    for (int i = 0; i < 16; i++) if (d[i]) x = 4'(i);
    return x;
  endfunction

  function automatic logic [3:0] rowPat(input int c);
    logic [3:0] p;
    p = 4'b1111;
    p[(c / SDI) % 4] = 1'b0;
    return p;
  endfunction

  // Reference model: cycle k after reset release drives row (k/SCAN_DIV)%4; the
  // last cycle of each row is the sample. A frame value repeated DEBOUNCE_N+1 times
  // in a row (reset counts as one all-zero frame) becomes the debounced map, and
  // the outputs follow three cycles after the frame's final sample.
  int          mCyc;
  logic [1:0]  mRow;
  logic        mEnd;
  logic [3:0]  mNib [4];
  logic [15:0] mFrame;
  logic [15:0] mLast;
  logic [15:0] mDeb;
  int          mRun;
  int          mRunNext;
  int          pendAt;
  logic [3:0]  pendMov;
  logic [3:0]  pendCode;
  logic        pendKv;
  logic [3:0]  expMov;
  logic [3:0]  expCode;
  logic        expKv;

  assign mRow     = 2'((mCyc / SDI) % 4);
  assign mEnd     = ((mCyc % SDI) == SDI - 1) && (mRow == 2'd3);
  assign mFrame   = {keys[15:12], mNib[2], mNib[1], mNib[0]};
  assign mRunNext = (mFrame == mLast) ? mRun + 1 : 1;

  always @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      mCyc     <= 0;
      mLast    <= 16'd0;
      mRun     <= 1;
      mDeb     <= 16'd0;
      pendAt   <= -1;
      pendMov  <= 4'd0;
      pendCode <= 4'd0;
      pendKv   <= 1'b0;
      expMov   <= 4'd0;
      expKv    <= 1'b0;
      expCode  <= 4'd0;
      for (int r = 0; r < 4; r++) mNib[r] <= 4'd0;
    end else begin
      mCyc       <= mCyc + 1;
      mNib[mRow] <= keys[{mRow, 2'b00} +: 4];
      expKv      <= 1'b0;
      if (mEnd) begin
        mLast <= mFrame;
        mRun  <= mRunNext;
        if (mRunNext >= DNI + 1) begin
          mDeb     <= mFrame;
          pendAt   <= mCyc + 3;
          pendMov  <= movOf(mFrame);
          pendKv   <= (mDeb == 16'd0) && ($countones(mFrame) == 1);
          pendCode <= idxOf(mFrame);
        end
      end
      if (mCyc + 1 == pendAt) begin
        expMov <= pendMov;
        expKv  <= pendKv;
        if (pendKv) expCode <= pendCode;
      end
    end
  end

  task automatic alignFrame();
    for (int i = 0; i < 2 * SDI * 4 && (mCyc % (SDI * 4)) != 0; i++) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    @(negedge sys_clk);
    total += 4;
    if (row_out !== 4'b1110) begin bad++; $display("[TB] FAIL reset_row_out: got %b expected 1110", row_out); end
    if (mov !== 4'b0000) begin bad++; $display("[TB] FAIL reset_mov: got %b expected 0000", mov); end
    if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_key_valid: got %b expected 0", key_valid); end
    if (key_code !== 4'd0) begin bad++; $display("[TB] FAIL reset_key_code: got %0d expected 0", key_code); end
    RST_N = 1'b1;
  endtask

  task automatic test_scan_order();
    keys = 16'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      total += 3;
      if (row_out !== rowPat(mCyc)) begin bad++; $display("[TB] FAIL scan_row_out: got %b expected %b at cycle %0d", row_out, rowPat(mCyc), mCyc); end
      if (mov !== 4'b0000) begin bad++; $display("[TB] FAIL scan_mov: got %b expected 0000", mov); end
      if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL scan_key_valid: got %b expected 0", key_valid); end
    end
  endtask

  task automatic test_single_key();
    RST_N = 1'b0;
    keys  = 16'h0040;
    @(negedge sys_clk);
    RST_N  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge sys_clk);
      total += 3;
      if (mov !== expMov) begin bad++; $display("[TB] FAIL single_mov: got %b expected %b at cycle %0d", mov, expMov, mCyc); end
      if (key_valid !== expKv) begin bad++; $display("[TB] FAIL single_key_valid: got %b expected %b at cycle %0d", key_valid, expKv, mCyc); end
      if (key_code !== expCode) begin bad++; $display("[TB] FAIL single_key_code: got %0d expected %0d", key_code, expCode); end
      if (key_valid === 1'b1) pulses++;
    end
    total += 3;
    if (pulses != 1) begin bad++; $display("[TB] FAIL single_pulses: got %0d expected 1", pulses); end
    if (key_code !== 4'd6) begin bad++; $display("[TB] FAIL single_code6: got %0d expected 6", key_code); end
    if (mov !== 4'b0001) begin bad++; $display("[TB] FAIL single_mov_right: got %b expected 0001", mov); end
  endtask

  task automatic test_bounce();
    keys = 16'd0;
    for (int i = 0; i < 96; i++) begin
      @(negedge sys_clk);
      total += 2;
      if (mov !== expMov) begin bad++; $display("[TB] FAIL bounce_release_mov: got %b expected %b", mov, expMov); end
      if (key_valid !== expKv) begin bad++; $display("[TB] FAIL bounce_release_key_valid: got %b expected %b", key_valid, expKv); end
    end
    alignFrame();
    pulses = 0;
    keys   = 16'h0002;
    for (int i = 0; i < 112; i++) begin
      if (i == 32) keys = 16'd0;
      @(negedge sys_clk);
      total += 3;
      if (mov !== 4'b0000) begin bad++; $display("[TB] FAIL bounce_mov: got %b expected 0000", mov); end
      if (mov !== expMov) begin bad++; $display("[TB] FAIL bounce_model_mov: got %b expected %b", mov, expMov); end
      if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL bounce_key_valid: got %b expected 0", key_valid); end
    end
  endtask

  task automatic test_opposing();
    logic [15:0] sets [2];
    logic [3:0]  want [2];
    sets[0] = 16'h0052; want[0] = 4'b1000;
    sets[1] = 16'h0212; want[1] = 4'b0010;
    pulses = 0;
    for (int s = 0; s < 2; s++) begin
      alignFrame();
      keys = sets[s];
      for (int i = 0; i < 96; i++) begin
        @(negedge sys_clk);
        total += 2;
        if (mov !== expMov) begin bad++; $display("[TB] FAIL opposing_mov: got %b expected %b", mov, expMov); end
        if (key_valid !== expKv) begin bad++; $display("[TB] FAIL opposing_key_valid: got %b expected %b", key_valid, expKv); end
        if (key_valid === 1'b1) pulses++;
      end
      total++;
      if (mov !== want[s]) begin bad++; $display("[TB] FAIL opposing_final_mov: got %b expected %b", mov, want[s]); end
    end
    total++;
    if (pulses != 0) begin bad++; $display("[TB] FAIL opposing_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_reset_mid();
    keys = 16'd0;
    repeat (96) @(negedge sys_clk);
    keys = 16'h0200;
    for (int i = 0; i < 120 && mov !== 4'b0100; i++) @(negedge sys_clk);
    total++;
    if (mov !== 4'b0100) begin bad++; $display("[TB] FAIL midreset_wait_down: got %b expected 0100", mov); end
    for (int i = 0; i < 20 && row_out !== 4'b1011; i++) @(negedge sys_clk);
    total++;
    if (row_out !== 4'b1011) begin bad++; $display("[TB] FAIL midreset_wait_row2: got %b expected 1011", row_out); end
    #2 RST_N = 1'b0;
    #1;
    total += 3;
    if (mov !== 4'b0000) begin bad++; $display("[TB] FAIL midreset_mov: got %b expected 0000", mov); end
    if (row_out !== 4'b1110) begin bad++; $display("[TB] FAIL midreset_row_out: got %b expected 1110", row_out); end
    if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_key_valid: got %b expected 0", key_valid); end
    @(negedge sys_clk);
    RST_N = 1'b1;
    #1;
    total++;
    if (row_out !== 4'b1110) begin bad++; $display("[TB] FAIL midreset_release_row: got %b expected 1110", row_out); end
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      total++;
      if (row_out !== rowPat(mCyc)) begin bad++; $display("[TB] FAIL midreset_restart_row: got %b expected %b", row_out, rowPat(mCyc)); end
    end
  endtask

  task automatic test_repress();
    logic [15:0] phase [3];
    phase[0] = 16'h0200; phase[1] = 16'h0000; phase[2] = 16'h0200;
    for (int p = 0; p < 3; p++) begin
      keys   = phase[p];
      pulses = 0;
      for (int i = 0; i < 96; i++) begin
        @(negedge sys_clk);
        total += 3;
        if (mov !== expMov) begin bad++; $display("[TB] FAIL repress_mov: got %b expected %b", mov, expMov); end
        if (key_valid !== expKv) begin bad++; $display("[TB] FAIL repress_key_valid: got %b expected %b", key_valid, expKv); end
        if (key_code !== expCode) begin bad++; $display("[TB] FAIL repress_key_code: got %0d expected %0d", key_code, expCode); end
        if (key_valid === 1'b1) pulses++;
      end
    end
    total += 3;
    if (pulses != 1) begin bad++; $display("[TB] FAIL repress_pulses: got %0d expected 1", pulses); end
    if (key_code !== 4'd9) begin bad++; $display("[TB] FAIL repress_code9: got %0d expected 9", key_code); end
    if (mov !== 4'b0100) begin bad++; $display("[TB] FAIL repress_mov_down: got %b expected 0100", mov); end
  endtask

  task automatic test_random();
    logic [15:0] k;
    logic [3:0]  d;
    int          hold;
    for (int it = 0; it < 25; it++) begin
      k = 16'd0;
      case ($urandom_range(0, 3))
        0: k = 16'd0;
        1: k = 16'h1 << $urandom_range(0, 15);
        2: k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: begin
          d = 4'($urandom_range(0, 15));
          k[1] = d[0]; k[9] = d[1]; k[4] = d[2]; k[6] = d[3];
        end
      endcase
      keys = k;
      hold = int'($urandom_range(1, 5)) * SDI * 4 + int'($urandom_range(0, 1)) * int'($urandom_range(0, SDI * 4 - 1));
      for (int i = 0; i < hold; i++) begin
        @(negedge sys_clk);
        total += 4;
        if (mov !== expMov) begin bad++; $display("[TB] FAIL random_mov: got %b expected %b keys %h", mov, expMov, keys); end
        if (key_valid !== expKv) begin bad++; $display("[TB] FAIL random_key_valid: got %b expected %b keys %h", key_valid, expKv, keys); end
        if (key_code !== expCode) begin bad++; $display("[TB] FAIL random_key_code: got %0d expected %0d", key_code, expCode); end
        if (row_out !== rowPat(mCyc)) begin bad++; $display("[TB] FAIL random_row_out: got %b expected %b", row_out, rowPat(mCyc)); end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_scan_order();
    test_single_key();
    test_bounce();
    test_opposing();
    test_reset_mid();
    test_repress();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
